// File: rtl/umtrx_err_arbiter_pkg.sv
// Shared constants and state encoding for the TX-chain error stream arbiter.
package umtrx_err_arbiter_pkg;

  localparam int STREAM_WIDTH = 36;
  localparam int SOF_BIT      = 32;
  localparam int EOF_BIT      = 33;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/umtrx_err_arbiter_if.sv
// Bundle of the NUM_CHAINS error-report inputs and the merged output stream.
interface umtrx_err_arbiter_if
  import umtrx_err_arbiter_pkg::*;
#(
  parameter int NUM_CHAINS = 2
) ();

  // A beat moves on any cycle where valid and ready are both high; valid must
  // not wait on ready, and a source holds its beat stable while stalled.
  logic [STREAM_WIDTH*NUM_CHAINS-1:0] in_data;
  logic [NUM_CHAINS-1:0]              in_valid;
  logic [NUM_CHAINS-1:0]              in_ready;
  logic [STREAM_WIDTH-1:0]            out_data;
  logic                               out_valid;
  logic                               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/umtrx_rr_pick.sv
// Combinational round-robin picker: first requester after the last grant, with wrap.
module umtrx_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last,
  output logic [1:0]         o_next,
  output logic               o_any
);

  always_comb begin
    int w_best;
    int w_dist;
    w_best = NUM_REQ;
    w_dist = 0;
    o_next = i_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      // distance 0 is the slot immediately after the last grant
      w_dist = (k + 2 * NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_next = 2'(k);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/umtrx_err_arbiter.sv
// Packet-locked round-robin merge of per-chain error streams with per-chain packet counters.
module umtrx_err_arbiter
  import umtrx_err_arbiter_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  umtrx_err_arbiter_if.slave              bus,
  output logic                            active,
  output logic [1:0]                      grant,
  output logic [CNT_WIDTH*NUM_CHAINS-1:0] pkt_count,
  input  logic                            clear_counts
);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [1:0]              r_grant;
  logic [1:0]              w_grant_nxt;
  logic [1:0]              w_pick;
  logic                    w_any;
  logic [STREAM_WIDTH-1:0] w_sel_data;
  logic                    w_sel_valid;
  logic [NUM_CHAINS-1:0]   w_grant_oh;
  logic [NUM_CHAINS-1:0]   w_in_ready;
  logic                    w_out_valid;
  logic                    w_inc;
  logic [CNT_WIDTH-1:0]    r_cnt [NUM_CHAINS];

  umtrx_rr_pick #(.NUM_REQ(NUM_CHAINS)) u_pick (
    .i_req  (bus.in_valid),
    .i_last (r_grant),
    .o_next (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_grant_oh  = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      if (r_grant == 2'(k)) begin
        w_sel_data    = bus.in_data[STREAM_WIDTH*k +: STREAM_WIDTH];
        w_sel_valid   = bus.in_valid[k];
        w_grant_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_in_ready  = '0;
    w_out_valid = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        // arbitration cycle: nothing transfers, the winner is latched for LOCKED
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        w_out_valid = w_sel_valid;
        w_in_ready  = w_grant_oh & {NUM_CHAINS{bus.out_ready}};
        if (w_sel_valid && bus.out_ready && w_sel_data[EOF_BIT]) begin
          w_inc       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 2'(NUM_CHAINS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // clear wins over a same-cycle EOF increment; counters wrap freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHAINS; k++) r_cnt[k] <= '0;
    end else if (clear_counts) begin
      for (int k = 0; k < NUM_CHAINS; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CHAINS; k++) begin
        if (w_inc && (r_grant == 2'(k))) r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_cnt
    assign pkt_count[CNT_WIDTH*g +: CNT_WIDTH] = r_cnt[g];
  end

  assign bus.out_data  = w_sel_data;
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign active        = (r_state == LOCKED);
  assign grant         = r_grant;

endmodule

// File: tb/tb_umtrx_err_arbiter.sv
// Bench for umtrx_err_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_umtrx_err_arbiter;
  import umtrx_err_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int W  = STREAM_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_counts = 1'b0;
  logic          active;
  logic [1:0]    grant;
  logic [CW*N-1:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  umtrx_err_arbiter_if #(.NUM_CHAINS(N)) bus ();

  umtrx_err_arbiter #(.NUM_CHAINS(N), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .active       (active),
    .grant        (grant),
    .pkt_count    (pkt_count),
    .clear_counts (clear_counts)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW-1:0] cnt_of(int k);
    return pkt_count[CW*k +: CW];
  endfunction

  function automatic logic [W-1:0] mk_beat(bit sof, bit eof, logic [31:0] pay);
    return {2'b00, eof, sof, pay};
  endfunction

  // behavioural model: packet-level arbitration with plain integer bookkeeping
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  bit           m_locked;
  int           m_grant;
  int           m_cnt[N];
  bit           m_found;
  bit           m_inc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 1'b0;
      m_grant  = N - 1;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      m_inc = 1'b0;
      if (!m_locked) begin
        m_found = 1'b0;
        for (int d = 1; d <= N; d++) begin
          if (!m_found && bus.in_valid[(m_grant + d) % N]) begin
            m_grant  = (m_grant + d) % N;
            m_found  = 1'b1;
            m_locked = 1'b1;
          end
        end
      end else if (bus.in_valid[m_grant] && bus.out_ready) begin
        exp_q.push_back(bus.in_data[W*m_grant +: W]);
        if (bus.in_data[W*m_grant + EOF_BIT]) begin
          m_locked = 1'b0;
          m_inc    = 1'b1;
        end
      end
      if (clear_counts) begin
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
      end else if (m_inc) begin
        m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << CW);
      end
    end
  end

  // monitor: record every beat the DUT actually hands downstream
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready) obs_q.push_back(bus.out_data);
  end

  // packet sources
  int src_left[N];
  int src_len[N];
  int src_beat[N];
  int src_pkt[N];
  bit src_hold[N];
  bit src_xfer[N];
  int src_fix_len;

  function automatic int new_len();
    return (src_fix_len > 0) ? src_fix_len : int'($urandom_range(1, 4));
  endfunction

  function automatic logic [W-1:0] src_data(int k);
    return mk_beat(src_beat[k] == 0, src_beat[k] == src_len[k] - 1,
                   {8'(k), 8'(src_pkt[k]), 8'(src_beat[k]), 8'(src_len[k])});
  endfunction

  task automatic src_init(int pkts, int fix_len);
    src_fix_len = fix_len;
    for (int k = 0; k < N; k++) begin
      src_left[k] = pkts;
      src_len[k]  = new_len();
      src_beat[k] = 0;
      src_pkt[k]  = 0;
      src_hold[k] = 1'b0;
      src_xfer[k] = 1'b0;
    end
  endtask

  task automatic src_drive(int vpct, int rpct, int cpct);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (src_left[k] == 0) src_hold[k] = 1'b0;
      else if (!src_hold[k]) src_hold[k] = ($urandom_range(0, 99) < vpct);
      bus.in_valid[k]          = src_hold[k];
      bus.in_data[W*k +: W]    = src_data(k);
    end
    bus.out_ready = ($urandom_range(0, 99) < rpct);
    clear_counts  = ($urandom_range(0, 99) < cpct);
    #1;
    for (int k = 0; k < N; k++) src_xfer[k] = bus.in_valid[k] && bus.in_ready[k];
  endtask

  task automatic src_advance();
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (src_xfer[k]) begin
        src_hold[k] = 1'b0;
        src_beat[k]++;
        if (src_beat[k] == src_len[k]) begin
          src_beat[k] = 0;
          src_pkt[k]++;
          src_left[k]--;
          src_len[k] = new_len();
        end
      end
    end
  endtask

  function automatic bit src_done();
    for (int k = 0; k < N; k++) if (src_left[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear_counts  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 000", bus.in_ready); end
    n_checks++; if (grant !== 2'(N - 1)) begin n_fail++; $display("FAIL reset_grant: got %0d expected %0d", grant, N - 1); end
    n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL reset_counts: got %h expected 0", pkt_count); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = '0;
  endtask

  task automatic test_single_packet();
    logic [W-1:0] b [3];
    b[0] = mk_beat(1'b1, 1'b0, 32'hA0A0_0001);
    b[1] = mk_beat(1'b0, 1'b0, 32'hA0A0_0002);
    b[2] = mk_beat(1'b0, 1'b1, 32'hA0A0_0003);
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 3'b001;
    bus.in_data[0 +: W] = b[0];
    #1;
    n_checks++; if (active !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got active=%b out_valid=%b expected 0/0", active, bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_data[0 +: W] = b[i];
      #1;
      n_checks++; if (active !== 1'b1 || grant !== 2'd0) begin n_fail++; $display("FAIL single_lock[%0d]: got active=%b grant=%0d expected 1/0", i, active, grant); end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== b[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %b/%h expected 1/%h", i, bus.out_valid, bus.out_data, b[i]); end
      n_checks++; if (bus.in_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected 001", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid = '0;
    #1;
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got %b expected 0", active); end
    n_checks++; if (cnt_of(0) !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d expected 1", cnt_of(0)); end
    n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL single_beats: got %0d expected 3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++; if (obs_q[i] !== b[i]) begin n_fail++; $display("FAIL single_seq[%0d]: got %h expected %h", i, obs_q[i], b[i]); end
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] want_q[$];
    int cyc;
    apply_reset();
    src_init(2, 2);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        for (int bt = 0; bt < 2; bt++)
          want_q.push_back(mk_beat(bt == 0, bt == 1, {8'(k), 8'(r), 8'(bt), 8'(2)}));
    cyc = 0;
    while (!src_done() && cyc < 200) begin
      src_drive(100, 100, 0);
      src_advance();
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = '0;
    #1;
    n_checks++; if (!src_done()) begin n_fail++; $display("FAIL fair_timeout: got %0d cycles expected completion", cyc); end
    n_checks++; if (obs_q.size() != want_q.size()) begin n_fail++; $display("FAIL fair_beats: got %0d expected %0d", obs_q.size(), want_q.size()); end
    else for (int i = 0; i < want_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== want_q[i]) begin n_fail++; $display("FAIL fair_order[%0d]: got %h expected %h", i, obs_q[i], want_q[i]); end
    end
    for (int k = 0; k < N; k++) begin
      n_checks++; if (cnt_of(k) !== CW'(2)) begin n_fail++; $display("FAIL fair_count[%0d]: got %0d expected 2", k, cnt_of(k)); end
    end
  endtask

  task automatic test_lock_hold();
    logic [W-1:0] p [3];
    logic [W-1:0] c0;
    p[0] = mk_beat(1'b1, 1'b0, 32'hB1B1_0000);
    p[1] = mk_beat(1'b0, 1'b0, 32'hB1B1_0001);
    p[2] = mk_beat(1'b0, 1'b1, 32'hB1B1_0002);
    c0   = mk_beat(1'b1, 1'b1, 32'hC0C0_0000);
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 3'b010;
    bus.in_data[W +: W] = p[0];
    @(negedge clk); #1;
    n_checks++; if (active !== 1'b1 || grant !== 2'd1) begin n_fail++; $display("FAIL hold_grant1: got active=%b grant=%0d expected 1/1", active, grant); end
    @(negedge clk);
    bus.in_data[W +: W] = p[1];
    bus.in_data[0 +: W] = c0;
    bus.in_valid = 3'b011;
    #1;
    n_checks++; if (bus.in_ready !== 3'b010) begin n_fail++; $display("FAIL hold_block_a: got %b expected 010", bus.in_ready); end
    @(negedge clk);
    bus.in_data[W +: W] = p[2];
    #1;
    n_checks++; if (bus.in_ready !== 3'b010 || bus.out_data !== p[2]) begin n_fail++; $display("FAIL hold_block_b: got %b/%h expected 010/%h", bus.in_ready, bus.out_data, p[2]); end
    @(negedge clk);
    bus.in_valid = 3'b001;
    #1;
    n_checks++; if (active !== 1'b0 || bus.in_ready !== 3'b000) begin n_fail++; $display("FAIL hold_idle: got active=%b ready=%b expected 0/000", active, bus.in_ready); end
    @(negedge clk); #1;
    n_checks++; if (grant !== 2'd0 || bus.in_ready !== 3'b001 || bus.out_data !== c0) begin n_fail++; $display("FAIL hold_grant0: got grant=%0d ready=%b data=%h expected 0/001/%h", grant, bus.in_ready, bus.out_data, c0); end
    @(negedge clk);
    bus.in_valid = '0;
    #1;
    n_checks++; if (cnt_of(0) !== CW'(1) || cnt_of(1) !== CW'(1)) begin n_fail++; $display("FAIL hold_counts: got %0d/%0d expected 1/1", cnt_of(0), cnt_of(1)); end
  endtask

  task automatic test_stall();
    logic [W-1:0] b [4];
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int idx;
    int exp_idx;
    int eof_cyc;
    for (int i = 0; i < 4; i++) b[i] = mk_beat(i == 0, i == 3, 32'h5700_0000 + 32'(i));
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 3'b001;
    bus.in_data[0 +: W] = b[0];
    idx = 0;
    exp_idx = 0;
    eof_cyc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.in_data[0 +: W] = b[(idx < 4) ? idx : 3];
      bus.out_ready = pat[c];
      #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== b[exp_idx]) begin n_fail++; $display("FAIL stall_data[%0d]: got %b/%h expected 1/%h", c, bus.out_valid, bus.out_data, b[exp_idx]); end
      if (bus.in_ready[0]) begin
        if (idx == 3 && eof_cyc == 0) eof_cyc = c + 1;
        idx++;
      end
      if (pat[c]) exp_idx++;
      if (exp_idx > 3) exp_idx = 3;
    end
    @(negedge clk);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (eof_cyc != 6) begin n_fail++; $display("FAIL stall_eof_cycle: got %0d expected 6", eof_cyc); end
    n_checks++; if (active !== 1'b0 || cnt_of(0) !== CW'(1)) begin n_fail++; $display("FAIL stall_end: got active=%b count=%0d expected 0/1", active, cnt_of(0)); end
    n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL stall_beats: got %0d expected 4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (obs_q[i] !== b[i]) begin n_fail++; $display("FAIL stall_seq[%0d]: got %h expected %h", i, obs_q[i], b[i]); end
    end
  endtask

  task automatic test_wrap_and_clear();
    int cyc;
    apply_reset();
    src_init(0, 1);
    src_left[0] = 300;
    cyc = 0;
    while (!src_done() && cyc < 800) begin
      src_drive(100, 100, 0);
      src_advance();
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = '0;
    #1;
    n_checks++; if (!src_done()) begin n_fail++; $display("FAIL wrap_timeout: got %0d cycles expected completion", cyc); end
    n_checks++; if (cnt_of(0) !== CW'(300 % (1 << CW))) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", cnt_of(0), 300 % (1 << CW)); end
    bus.in_valid = 3'b001;
    bus.in_data[0 +: W] = mk_beat(1'b1, 1'b1, 32'hDEAD_0001);
    @(negedge clk);
    clear_counts = 1'b1;
    #1;
    n_checks++; if (active !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_setup: got active=%b out_valid=%b expected 1/1", active, bus.out_valid); end
    @(negedge clk);
    clear_counts = 1'b0;
    bus.in_valid = '0;
    #1;
    n_checks++; if (cnt_of(0) !== '0) begin n_fail++; $display("FAIL clear_priority: got %0d expected 0", cnt_of(0)); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = mk_beat(i == 0, i == 3, 32'h7E00_0000 + 32'(i));
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 3'b010;
    bus.in_data[W +: W] = mk_beat(1'b1, 1'b1, 32'h1111_0001);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 3'b001;
    bus.in_data[0 +: W] = b[0];
    @(negedge clk);
    @(negedge clk);
    bus.in_data[0 +: W] = b[1];
    #1;
    n_checks++; if (active !== 1'b1 || grant !== 2'd0 || cnt_of(1) !== CW'(1)) begin n_fail++; $display("FAIL rstmid_pre: got active=%b grant=%0d cnt1=%0d expected 1/0/1", active, grant, cnt_of(1)); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (active !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid_async: got active=%b out_valid=%b ready=%b expected 0/0/000", active, bus.out_valid, bus.in_ready); end
    n_checks++; if (grant !== 2'(N - 1) || pkt_count !== '0) begin n_fail++; $display("FAIL rstmid_state: got grant=%0d counts=%h expected %0d/0", grant, pkt_count, N - 1); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 3'b011;
    bus.in_data[0 +: W] = mk_beat(1'b1, 1'b1, 32'h0000_0A0A);
    bus.in_data[W +: W] = mk_beat(1'b1, 1'b1, 32'h0000_0B0B);
    #1;
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", active); end
    @(negedge clk); #1;
    n_checks++; if (active !== 1'b1 || grant !== 2'd0) begin n_fail++; $display("FAIL rstmid_first_win: got active=%b grant=%0d expected 1/0", active, grant); end
    @(negedge clk);
    bus.in_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_ir;
    bit e_ov;
    int cyc;
    int errs;
    apply_reset();
    src_init(15, 0);
    cyc  = 0;
    errs = 0;
    while (!(src_done() && !m_locked) && cyc < 4000) begin
      src_drive(70, 70, 3);
      e_ov = m_locked && bus.in_valid[m_grant];
      e_ir = '0;
      if (m_locked && bus.out_ready) e_ir[m_grant] = 1'b1;
      n_checks++; if (active !== m_locked || grant !== 2'(m_grant)) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_state@%0d: got active=%b grant=%0d expected %b/%0d", cyc, active, grant, m_locked, m_grant); end
      n_checks++; if (bus.out_valid !== e_ov || bus.in_ready !== e_ir) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_hs@%0d: got valid=%b ready=%b expected %b/%b", cyc, bus.out_valid, bus.in_ready, e_ov, e_ir); end
      if (e_ov) begin
        n_checks++; if (bus.out_data !== bus.in_data[W*m_grant +: W]) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_data@%0d: got %h expected %h", cyc, bus.out_data, bus.in_data[W*m_grant +: W]); end
      end
      for (int k = 0; k < N; k++) begin
        n_checks++; if (cnt_of(k) !== CW'(m_cnt[k])) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_count[%0d]@%0d: got %0d expected %0d", k, cyc, cnt_of(k), m_cnt[k]); end
      end
      src_advance();
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = '0;
    clear_counts = 1'b0;
    n_checks++; if (!src_done()) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles expected completion", cyc); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_beats: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_packet();
    test_fairness();
    test_lock_hold();
    test_stall();
    test_wrap_and_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
